// File: rtl/idct_recon_pkg.sv
// Shared constants, bank states and saturate/clip helpers for the IDCT reconstruction path.
package idct_pkg;

  localparam int IN_W  = 25;
  localparam int RES_W = 16;
  localparam int PIX_W = 8;
  localparam int SUM_W = 18;

  localparam int RES_MAX = (1 << (RES_W - 1)) - 1;
  localparam int RES_MIN = -(1 << (RES_W - 1));

  // The IDCT core runs an 8-phase schedule; phase 0 is idle here.
  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_FIRST = 3'd1;
  localparam logic [2:0] PH_LAST  = 3'd7;

  typedef enum logic [1:0] {FREE, FILL, FULL, DRAIN} bank_state_e;

  function automatic logic signed [RES_W-1:0] sat_res(input logic signed [IN_W-1:0] x);
    int v;
    v = int'(x);
    if (v > RES_MAX) v = RES_MAX;
    else if (v < RES_MIN) v = RES_MIN;
    return RES_W'(v);
  endfunction

  function automatic logic [PIX_W-1:0] clip_pix(input logic [PIX_W-1:0] pred,
                                                 input logic signed [RES_W-1:0] res);
    logic signed [SUM_W-1:0] s;
    s = $signed({{(SUM_W - PIX_W){1'b0}}, pred}) + $signed({{(SUM_W - RES_W){res[RES_W-1]}}, res});
    if (s[SUM_W-1]) return '0;
    else if (|s[SUM_W-2:PIX_W]) return '1;
    else return s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/idct_recon_if.sv
// Lane/prediction input bundle and reconstructed-row valid/ready output of idct_recon.
interface idct_recon_if;
  import idct_pkg::*;

  logic                    in_sync;
  logic signed [IN_W-1:0]  in_1;
  logic signed [IN_W-1:0]  in_2;
  logic signed [IN_W-1:0]  in_3;
  logic signed [IN_W-1:0]  in_4;
  logic [16*PIX_W-1:0]     pred_blk;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              out_row;
  logic [4*PIX_W-1:0]      out_pix;
  logic                    out_last;
  logic                    ovf;

  modport master (
    output in_sync, in_1, in_2, in_3, in_4, pred_blk, out_ready,
    input  out_valid, out_row, out_pix, out_last, ovf
  );

  modport slave (
    input  in_sync, in_1, in_2, in_3, in_4, pred_blk, out_ready,
    output out_valid, out_row, out_pix, out_last, ovf
  );
endinterface

// File: rtl/idct_recon_bank.sv
// One 4x4 block store: per-column residual write ports (row-indexed), whole-block prediction
// write, combinational row read. No reset; bank state lives in the parent.
module idct_recon_bank
  import idct_pkg::*;
(
  input  logic                        clk,
  input  logic                        i_pred_we,
  input  logic [16*PIX_W-1:0]         i_pred_blk,
  input  logic [3:0]                  i_res_we,
  input  logic [3:0][1:0]             i_res_row,
  input  logic [3:0][RES_W-1:0]       i_res_dat,
  input  logic [1:0]                  i_rd_row,
  output logic [3:0][RES_W-1:0]       o_rd_res,
  output logic [4*PIX_W-1:0]          o_rd_pred
);

  logic [RES_W-1:0] r_res  [16];
  logic [PIX_W-1:0] r_pred [16];

  always_ff @(posedge clk) begin
    if (i_pred_we) begin
      for (int k = 0; k < 16; k++) r_pred[k] <= i_pred_blk[k*PIX_W +: PIX_W];
    end
    for (int c = 0; c < 4; c++) begin
      if (i_res_we[c]) r_res[{i_res_row[c], 2'(c)}] <= i_res_dat[c];
    end
  end

  always_comb begin
    o_rd_res  = '0;
    o_rd_pred = '0;
    for (int c = 0; c < 4; c++) begin
      o_rd_res[c]                 = r_res[{i_rd_row, 2'(c)}];
      o_rd_pred[c*PIX_W +: PIX_W] = r_pred[{i_rd_row, 2'(c)}];
    end
  end

endmodule

// File: rtl/idct_recon.sv
// Deskews IDCT lanes into a ping-pong block buffer, adds prediction, clips, streams rows.
// First row 8 cycles after in_sync; output held under backpressure, blocks dropped when both banks busy.
module idct_recon
  import idct_pkg::*;
(
  input logic          clk,
  input logic          reset,
  idct_recon_if.slave  bus
);

  logic [2:0]  r_phase;
  logic        r_fill_vld;
  logic        r_fill_bank;
  bank_state_e r_state [2];
  logic        r_older;
  logic        r_out_vld;
  logic [1:0]  r_row;
  logic [4*PIX_W-1:0] r_pix;
  logic        r_last;
  logic        r_dbank;
  logic        r_ovf;

  logic        w_accept, w_sync_err, w_any_free, w_alloc;
  logic [2:0]  w_phase;
  logic        w_fill_vld, w_fill_bank, w_fill_done;
  logic [1:0]  w_pred_we;
  logic signed [IN_W-1:0] w_lane [4];
  logic [3:0]             w_we;
  logic [3:0][1:0]        w_wrow;
  logic [3:0][RES_W-1:0]  w_wdat;
  logic        w_take, w_next_row, w_release, w_any_full, w_pick, w_ld_new, w_ld_bank;
  logic [1:0]  w_ld_row;
  logic [3:0][RES_W-1:0]  w_rd_res  [2];
  logic [4*PIX_W-1:0]     w_rd_pred [2];
  logic [3:0][RES_W-1:0]  w_sel_res;
  logic [4*PIX_W-1:0]     w_sel_pred;
  logic [4*PIX_W-1:0]     w_pix;

  // The in_sync cycle itself is phase 1; r_phase holds the phase of the following cycle.
  assign w_accept    = bus.in_sync && (r_phase == PH_IDLE);
  assign w_sync_err  = bus.in_sync && (r_phase != PH_IDLE);
  assign w_any_free  = (r_state[0] == FREE) || (r_state[1] == FREE);
  assign w_alloc     = (r_state[0] != FREE);
  assign w_phase     = w_accept ? PH_FIRST : r_phase;
  assign w_fill_vld  = w_accept ? w_any_free : r_fill_vld;
  assign w_fill_bank = w_accept ? w_alloc : r_fill_bank;
  assign w_fill_done = w_fill_vld && (w_phase == PH_LAST);

  assign w_lane[0] = bus.in_1;
  assign w_lane[1] = bus.in_2;
  assign w_lane[2] = bus.in_3;
  assign w_lane[3] = bus.in_4;

  // Lane j+1 carries row (phase - j - 1) of column j while that row is 0..3.
  always_comb begin
    logic [3:0] v_d;
    v_d    = '0;
    w_we   = '0;
    w_wrow = '0;
    w_wdat = '0;
    for (int j = 0; j < 4; j++) begin
      v_d       = {1'b0, w_phase} - 4'(j + 1);
      w_we[j]   = w_fill_vld && (w_phase > 3'(j)) && (v_d < 4'd4);
      w_wrow[j] = v_d[1:0];
      w_wdat[j] = sat_res(w_lane[j]);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign w_pred_we[g] = w_accept && w_any_free && (w_alloc == 1'(g));

    idct_recon_bank u_bank (
      .clk        (clk),
      .i_pred_we  (w_pred_we[g]),
      .i_pred_blk (bus.pred_blk),
      .i_res_we   (w_we & {4{w_fill_bank == 1'(g)}}),
      .i_res_row  (w_wrow),
      .i_res_dat  (w_wdat),
      .i_rd_row   (w_ld_row),
      .o_rd_res   (w_rd_res[g]),
      .o_rd_pred  (w_rd_pred[g])
    );
  end

  assign w_take     = !r_out_vld || bus.out_ready;
  assign w_next_row = r_out_vld && !r_last;
  assign w_release  = r_out_vld && bus.out_ready && r_last;
  assign w_any_full = (r_state[0] == FULL) || (r_state[1] == FULL);
  assign w_pick     = ((r_state[0] == FULL) && (r_state[1] == FULL)) ? r_older : (r_state[1] == FULL);
  assign w_ld_new   = w_take && !w_next_row && w_any_full;
  assign w_ld_bank  = w_next_row ? r_dbank : w_pick;
  assign w_ld_row   = w_next_row ? r_row + 2'd1 : 2'd0;
  assign w_sel_res  = w_rd_res[w_ld_bank];
  assign w_sel_pred = w_rd_pred[w_ld_bank];

  always_comb begin
    w_pix = '0;
    for (int c = 0; c < 4; c++) begin
      w_pix[c*PIX_W +: PIX_W] = clip_pix(w_sel_pred[c*PIX_W +: PIX_W], w_sel_res[c]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase     <= PH_IDLE;
      r_fill_vld  <= 1'b0;
      r_fill_bank <= 1'b0;
      r_older     <= 1'b0;
      r_ovf       <= 1'b0;
      for (int b = 0; b < 2; b++) r_state[b] <= FREE;
    end else begin
      r_phase     <= ((w_phase != PH_IDLE) && (w_phase != PH_LAST)) ? w_phase + 3'd1 : PH_IDLE;
      r_fill_vld  <= w_fill_vld && (w_phase != PH_IDLE) && (w_phase != PH_LAST);
      r_fill_bank <= w_fill_bank;
      if (w_sync_err || (w_accept && !w_any_free)) r_ovf <= 1'b1;
      for (int b = 0; b < 2; b++) begin
        if (w_pred_we[b]) begin
          r_state[b] <= FILL;
        end else if (w_fill_done && (w_fill_bank == 1'(b))) begin
          r_state[b] <= FULL;
          // When the other bank already waits FULL it predates this one.
          r_older    <= (r_state[1-b] == FULL) ? 1'(1 - b) : 1'(b);
        end else if (w_ld_new && (w_pick == 1'(b))) begin
          r_state[b] <= DRAIN;
        end else if (w_release && (r_dbank == 1'(b))) begin
          r_state[b] <= FREE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_vld <= 1'b0;
      r_row     <= 2'd0;
      r_pix     <= '0;
      r_last    <= 1'b0;
      r_dbank   <= 1'b0;
    end else if (w_take) begin
      if (w_next_row || w_any_full) begin
        r_out_vld <= 1'b1;
        r_row     <= w_ld_row;
        r_pix     <= w_pix;
        r_last    <= (w_ld_row == 2'd3);
        r_dbank   <= w_ld_bank;
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.out_row   = r_row;
  assign bus.out_pix   = r_pix;
  assign bus.out_last  = r_last;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_idct_recon.sv
// Randomised scoreboard bench for idct_recon: block-level reference model feeds an expected-row queue.
module tb_idct_recon;
  import idct_pkg::*;

  typedef struct {
    logic [1:0]  row;
    logic [31:0] pix;
    logic        last;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  idct_recon_if bus ();

  idct_recon dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks     = 0;
  int   failures   = 0;
  exp_t sb_q[$];
  int   held       = 0;
  logic exp_ovf    = 1'b0;
  int   ready_mode = 1;
  int   cur_res  [4][4];
  int   cur_pred [16];

  function automatic int pix_of(int p, int r);
    int s;
    s = r;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    s = s + p;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic logic signed [IN_W-1:0] junk();
    return IN_W'($urandom);
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drive_ready();
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic drive_idle(int n);
    repeat (n) begin
      bus.in_sync  = 1'b0;
      bus.in_1     = junk();
      bus.in_2     = junk();
      bus.in_3     = junk();
      bus.in_4     = junk();
      bus.pred_blk = {4{$urandom}};
      drive_ready();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rand_block();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        case ($urandom_range(0, 9))
          0:       cur_res[r][c] = int'($urandom_range(32000, 16777215));
          1:       cur_res[r][c] = -int'($urandom_range(32000, 16777216));
          default: cur_res[r][c] = int'($urandom_range(0, 600)) - 300;
        endcase
        cur_pred[4*r+c] = int'($urandom_range(0, 255));
      end
    end
  endtask

  // Drives one block over phases 1..7; abort_ph>0 asserts reset in that phase instead.
  task automatic send_block(int extra_ph, int abort_ph);
    logic signed [IN_W-1:0] lv [4];
    logic [127:0] pb;
    exp_t e;
    if (abort_ph == 0) begin
      if (held < 2) begin
        held++;
        for (int r = 0; r < 4; r++) begin
          e.row  = 2'(r);
          e.last = (r == 3);
          e.pix  = '0;
          for (int c = 0; c < 4; c++) e.pix[c*8 +: 8] = 8'(pix_of(cur_pred[4*r+c], cur_res[r][c]));
          sb_q.push_back(e);
        end
      end else begin
        exp_ovf = 1'b1;
      end
    end
    for (int k = 0; k < 16; k++) pb[k*8 +: 8] = 8'(cur_pred[k]);
    for (int p = 1; p <= 7; p++) begin
      if (p == abort_ph) begin
        reset       = 1'b0;
        bus.in_sync = 1'b0;
        #1;
        check("rst_mid_valid", bus.out_valid, 0);
        check("rst_mid_row",   bus.out_row,   0);
        check("rst_mid_pix",   bus.out_pix,   0);
        check("rst_mid_last",  bus.out_last,  0);
        check("rst_mid_ovf",   bus.ovf,       0);
        sb_q.delete();
        held    = 0;
        exp_ovf = 1'b0;
        return;
      end
      bus.in_sync = (p == 1) || (p == extra_ph);
      for (int j = 1; j <= 4; j++) begin
        if ((p - j >= 0) && (p - j <= 3)) lv[j-1] = IN_W'(cur_res[p-j][j-1]);
        else lv[j-1] = junk();
      end
      bus.in_1 = lv[0];
      bus.in_2 = lv[1];
      bus.in_3 = lv[2];
      bus.in_4 = lv[3];
      bus.pred_blk = (p == 1) ? pb : {4{$urandom}};
      drive_ready();
      @(posedge clk);
      #1;
    end
    if (extra_ph >= 2 && extra_ph <= 7) exp_ovf = 1'b1;
    bus.in_sync = 1'b0;
  endtask

  task automatic wait_drain(int bound);
    int n;
    n = 0;
    ready_mode = 1;
    while ((sb_q.size() != 0 || bus.out_valid) && n < bound) begin
      drive_idle(1);
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || bus.out_valid) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d valid=%0d want pending=0 valid=0", sb_q.size(), bus.out_valid);
    end
  endtask

  // Monitor: stability under backpressure plus in-order row scoreboard.
  initial begin
    logic        have_prev;
    logic [35:0] prev;
    exp_t        e;
    have_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        have_prev = 1'b0;
      end else begin
        if (have_prev) check("hold_stable", {bus.out_valid, bus.out_row, bus.out_pix, bus.out_last}, prev);
        have_prev = bus.out_valid && !bus.out_ready;
        prev      = {bus.out_valid, bus.out_row, bus.out_pix, bus.out_last};
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL row_unexpected got row=%0d pix=%08h want no row", bus.out_row, bus.out_pix);
          end else begin
            e = sb_q.pop_front();
            if (bus.out_row !== e.row || bus.out_pix !== e.pix || bus.out_last !== e.last) begin
              failures++;
              $display("FAIL row_data got row=%0d pix=%08h last=%0d want row=%0d pix=%08h last=%0d",
                       bus.out_row, bus.out_pix, bus.out_last, e.row, e.pix, e.last);
            end
            if (e.last) held--;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    bus.in_sync   = 1'b0;
    bus.in_1      = '0;
    bus.in_2      = '0;
    bus.in_3      = '0;
    bus.in_4      = '0;
    bus.pred_blk  = '0;
    bus.out_ready = 1'b0;
    #1 reset = 1'b0;
    #2;
    check("rst_valid", bus.out_valid, 0);
    check("rst_row",   bus.out_row,   0);
    check("rst_pix",   bus.out_pix,   0);
    check("rst_last",  bus.out_last,  0);
    check("rst_ovf",   bus.ovf,       0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ready_mode = 1;
    drive_idle(1);

    // Zero residual, flat 0x80 prediction, plus first-row latency.
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      cur_res[r][c]   = 0;
      cur_pred[4*r+c] = 128;
    end
    send_block(0, 0);
    check("lat_before", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_first", bus.out_valid, 1);

    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      cur_res[r][c]   = 4*r + c;
      cur_pred[4*r+c] = 0;
    end
    send_block(0, 0);
    drive_idle(1);

    rand_block();
    cur_res[0][0] = 300;       cur_pred[0] = 10;
    cur_res[0][1] = -50;       cur_pred[1] = 20;
    cur_res[0][2] = 16777215;  cur_pred[2] = 0;
    cur_res[0][3] = -16777216; cur_pred[3] = 255;
    send_block(0, 0);
    wait_drain(100);
    check("ovf_clean", bus.ovf, exp_ovf);

    rand_block();
    send_block(4, 0);
    wait_drain(100);
    check("ovf_late_sync", bus.ovf, exp_ovf);

    rand_block();
    send_block(0, 5);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drive_idle(1);
    rand_block();
    send_block(0, 0);
    wait_drain(100);
    check("ovf_after_rst", bus.ovf, exp_ovf);

    for (int b = 0; b < 10; b++) begin
      rand_block();
      send_block(0, 0);
      drive_idle(1);
    end
    wait_drain(100);
    check("ovf_stream", bus.ovf, exp_ovf);

    // Backpressure: third block finds both banks busy and is dropped.
    ready_mode = 0;
    for (int b = 0; b < 3; b++) begin
      rand_block();
      send_block(0, 0);
      drive_idle(1);
    end
    check("ovf_drop", bus.ovf, exp_ovf);
    drive_idle(3);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("bp_beat", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("bp_idle", bus.out_valid, 0);
    @(posedge clk);
    #1;
    wait_drain(100);

    for (int b = 0; b < 40; b++) begin
      ready_mode = 2;
      rand_block();
      extra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 7)) : 0;
      send_block(extra, 0);
      drive_idle(int'($urandom_range(0, 4)));
    end
    wait_drain(400);
    check("ovf_random", bus.ovf, exp_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idct_recon.md
Name: idct_recon

Overview:
- Downstream neighbour of the 4-point two-pass IDCT core.
- Takes the core's four diagonally skewed residual output lanes and deskews one 4x4 residual block into a ping-pong buffer.
- Adds the block's 8-bit prediction, clips each sum to pixel range and streams reconstructed rows to the frame writer over a valid/ready handshake.

Parameters:
- IN_W, 25, width of each signed IDCT output lane.
- RES_W, 16, signed residual storage width (saturated on capture).
- PIX_W, 8, unsigned prediction/pixel width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_sync  input  1  pulse in the cycle the IDCT core is in phase 1 of a block (lane 1 carries row0 col0).
- in_1..in_4  input  IN_W each  signed IDCT output lanes 1..4.
- pred_blk  input  16*PIX_W  prediction pixel (r,c) at bits [8*(4r+c)+7 : 8*(4r+c)]; sampled on the in_sync cycle.
- out_valid  output  1  a reconstructed row is presented.
- out_ready  input  1  downstream accepts the row.
- out_row  output  2  row index 0..3.
- out_pix  output  4*PIX_W  column c at bits [8c+7:8c].
- out_last  output  1  high with row 3.
- ovf  output  1  sticky error flag.

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, out_row=0, out_pix=0, out_last=0, ovf=0, both banks FREE, phase counter idle. Clears everything mid-operation, including any partially filled bank.
- Phase counter:
  - Accepted in_sync loads phase=1; phase then increments each cycle to 7 and returns to idle.
  - An in_sync arriving while phase is 2..7 is ignored and sets ovf.
- Bank states: FREE -> FILL -> FULL -> DRAIN -> FREE.
- Bank selection on accepted in_sync:
  - The lower-indexed FREE bank enters FILL and captures pred_blk.
  - If no bank is FREE, the block is dropped: phase still runs, nothing is written, ovf is set.
  - A bank freed on the same edge is not visible to in_sync until the next cycle.
- Capture rule: at phase p, lane j (1..4) with r = p - j in 0..3 writes residual(r, j-1). All other lane values are ignored.
- Residual saturation on capture: sat(x) = clamp(x, -32768, 32767).
- End of fill: at the end of phase 7 the bank becomes FULL.
- Drain order:
  - FULL banks drain oldest first.
  - The output register loads row r of the draining bank with pix(r,c) = clamp(pred(r,c) + res(r,c), 0, 255), computed at 18-bit signed width.
- Latency: first out_valid of a block is 8 cycles after its in_sync when out_ready=1 and the output is idle.
- Handshake:
  - out_valid, out_row, out_pix and out_last are registered and held stable while out_valid=1 and out_ready=0.
  - A transfer occurs on the edge where out_valid and out_ready are both 1.
  - On transfer, the next row, or row 0 of the next FULL bank, loads on the same edge with no bubble. out_valid drops only if nothing is pending.
- Release: the bank returns to FREE on the transfer of row 3.
- Sustained throughput: one block per 8 cycles with no drops when out_ready is held high.
- ovf clears only on reset.

Decomposition:
- Shared package idct_pkg:
  - Constants IN_W, RES_W, PIX_W.
  - Phase constants PH_FIRST=1 and PH_LAST=7 (common with the IDCT core's 8-phase schedule).
  - Bank-state enum {FREE, FILL, FULL, DRAIN}.
  - Saturate/clip functions.
- One sub-module, idct_recon_bank: a single 16xRES_W residual plus 16xPIX_W prediction store, with a write port indexed by (row, col) and a row read port. Instantiated twice.

Test Plan:
- Zero residual on all lanes, pred all 0x80, out_ready=1 -> out_pix=0x80808080 on rows 0..3; first out_valid 8 cycles after in_sync; out_last only on row 3.
- Lanes driven so residual(r,c)=4r+c under the skew rule, pred=0 -> row0=0x03020100, row1=0x07060504, row3=0x0F0E0D0C.
- Clipping:
  - res=+300 with pred=10 -> 0xFF.
  - res=-50 with pred=20 -> 0x00.
  - lane value 0x0FFFFFF with pred=0 -> 0xFF (saturated at 32767).
- Backpressure: out_ready=0; syncs at t, t+8, t+16 -> third block dropped and ovf=1. Row 0 of block 1 held stable. After out_ready=1, blocks 1 then 2 drain as 8 consecutive beats.
- Streaming: out_ready=1, syncs every 8 cycles for 10 blocks -> 40 rows in order, ovf=0.
- in_sync during phase 4 -> ignored, ovf=1, current block still correct. reset=0 during phase 5 -> all outputs 0 immediately, next block after release reconstructs correctly.
